// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel-style edge detector.
//   mode_e   : gradient selection (H, V, saturating H+V, max(H,V))
//   PIX_W    : RGB pixel width
//   EDGE_PIX : output pixel for an edge (white)
//   BG_PIX   : output pixel for background (black)
//   luma8()  : (R + 2G + B) >> 2 on a 24-bit RGB pixel, 8-bit result
package sobel_pkg;

  localparam int PIX_W = 24;
  localparam logic [PIX_W-1:0] EDGE_PIX = 24'hFFFFFF;
  localparam logic [PIX_W-1:0] BG_PIX   = 24'h000000;

  typedef enum logic [1:0] {
    MODE_H   = 2'd0,
    MODE_V   = 2'd1,
    MODE_SUM = 2'd2,
    MODE_MAX = 2'd3
  } mode_e;

  // The 10-bit sum cannot overflow (4 * 255 = 1020), so dropping the two
  // LSBs always leaves a full-range 8-bit luma.
  function automatic logic [7:0] luma8(input logic [PIX_W-1:0] pix);
    logic [9:0] sum;
    sum = {2'b00, pix[23:16]} + {1'b0, pix[15:8], 1'b0} + {2'b00, pix[7:0]};
    return sum[9:2];
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line luma memory: one write port, one synchronous read port.
//   clock     : rising-edge clock
//   i_rd_en   : read enable; o_rd_data holds its value while low
//   i_rd_addr : read column
//   o_rd_data : registered read data (value stored one row earlier)
//   i_wr_en   : write enable
//   i_wr_addr : write column
//   i_wr_data : luma sample to store
module sobel_line_buffer #(
  parameter  int DEPTH  = 640,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto plain RAM; row 0
  // never uses what it reads, so stale contents are harmless.
  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/sobel_stream_edge.sv
// Streaming edge detector: RGB in, binary white/black out, raster order.
// Two pipeline stages share one advance enable, so back-pressure from the
// sink freezes the whole pipe and propagates straight back to the source.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready is combinational)
//   in_pix, in_sof      : RGB pixel and first-pixel-of-frame marker
//   threshold, mode     : edge threshold and gradient select, per pixel
//   out_valid/out_ready : output handshake
//   out_pix, out_sof    : white/black pixel and its frame-start marker
module sobel_stream_edge
  import sobel_pkg::*;
#(
  parameter int LINE_W   = 640,
  parameter int SAMPLE_W = 8,
  parameter int ROW_W    = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PIX_W-1:0]    in_pix,
  input  logic                in_sof,
  input  logic [SAMPLE_W:0]   threshold,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PIX_W-1:0]    out_pix,
  output logic                out_sof
);

  localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam int G_W = SAMPLE_W + 1;

  logic                w_adv;
  logic                w_accept;
  logic [7:0]          w_luma8;
  logic [SAMPLE_W-1:0] w_luma;
  logic [COL_W-1:0]    w_pix_col;
  logic [ROW_W-1:0]    w_pix_row;
  logic [SAMPLE_W-1:0] w_up;
  logic [SAMPLE_W-1:0] w_h;
  logic [SAMPLE_W-1:0] w_v;
  logic [G_W:0]        w_sum;
  logic [G_W-1:0]      w_g;
  logic                w_edge;

  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [SAMPLE_W-1:0] r_left;
  logic                r_s1_valid;
  logic [SAMPLE_W-1:0] r_s1_luma;
  logic [SAMPLE_W-1:0] r_s1_left;
  logic [COL_W-1:0]    r_s1_col;
  logic                r_s1_row_zero;
  logic                r_s1_sof;
  logic [SAMPLE_W:0]   r_s1_thr;
  mode_e               r_s1_mode;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_accept = in_valid && w_adv;

  assign w_luma8 = luma8(in_pix);
  assign w_luma  = w_luma8[7 -: SAMPLE_W];

  // A frame start restarts position tracking no matter where the counters are.
  assign w_pix_col = in_sof ? '0 : r_col;
  assign w_pix_row = in_sof ? '0 : r_row;

  sobel_line_buffer #(
    .DEPTH (LINE_W),
    .WIDTH (SAMPLE_W)
  ) u_line_buffer (
    .clock     (clock),
    .i_rd_en   (w_adv),
    .i_rd_addr (w_pix_col),
    .o_rd_data (w_up),
    .i_wr_en   (w_adv && r_s1_valid),
    .i_wr_addr (r_s1_col),
    .i_wr_data (r_s1_luma)
  );

  // Control state: counters and valid bits, reset to a clean frame start.
  // NOTE: every clocked assignment is non-blocking so all registers see the
  // pre-edge values of each other, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_s1_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_pix    <= BG_PIX;
      out_sof    <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        if (w_pix_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (w_pix_row == '1) ? w_pix_row : w_pix_row + 1'b1;
        end else begin
          r_col <= w_pix_col + 1'b1;
          r_row <= w_pix_row;
        end
      end
      out_valid <= r_s1_valid;
      out_sof   <= r_s1_valid && r_s1_sof;
      if (r_s1_valid) out_pix <= w_edge ? EDGE_PIX : BG_PIX;
    end
  end

  // Datapath state: only ever read alongside a set valid bit.
  always_ff @(posedge clock) begin
    if (w_adv && w_accept) begin
      r_left        <= w_luma;
      r_s1_luma     <= w_luma;
      r_s1_left     <= r_left;
      r_s1_col      <= w_pix_col;
      r_s1_row_zero <= (w_pix_row == '0);
      r_s1_sof      <= in_sof;
      r_s1_thr      <= threshold;
      r_s1_mode     <= mode_e'(mode);
    end
  end

  // Stage 2: absolute differences against the left and upper neighbours.
  assign w_h = (r_s1_col == '0) ? '0 :
               (r_s1_luma >= r_s1_left) ? r_s1_luma - r_s1_left : r_s1_left - r_s1_luma;
  assign w_v = r_s1_row_zero ? '0 :
               (r_s1_luma >= w_up) ? r_s1_luma - w_up : w_up - r_s1_luma;
  assign w_sum = {2'b00, w_h} + {2'b00, w_v};

  // NOTE: w_g gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_g = '0;
    case (r_s1_mode)
      MODE_H:   w_g = {1'b0, w_h};
      MODE_V:   w_g = {1'b0, w_v};
      MODE_SUM: w_g = w_sum[G_W] ? '1 : w_sum[G_W-1:0];
      MODE_MAX: w_g = (w_h >= w_v) ? {1'b0, w_h} : {1'b0, w_v};
      default:  w_g = '0;
    endcase
  end

  assign w_edge = (w_g >= r_s1_thr);

endmodule

// File: tb/tb_sobel_stream_edge.sv
// Directed bench for sobel_stream_edge with LINE_W=4, SAMPLE_W=8.
// Each pixel is sent with its hand-computed expected output; a monitor
// compares every output transfer in order, checks the two-cycle latency,
// and checks that outputs hold still while the sink stalls.
module tb_sobel_stream_edge;

  localparam logic [23:0] EDGE = 24'hFFFFFF;
  localparam logic [23:0] BG   = 24'h000000;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pix;
  logic        in_sof;
  logic [8:0]  threshold;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_pix;
  logic        out_sof;

  sobel_stream_edge #(
    .LINE_W   (4),
    .SAMPLE_W (8),
    .ROW_W    (10)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_sof    (in_sof),
    .threshold (threshold),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_sof   (out_sof)
  );

  typedef struct {
    logic [23:0] pix;
    logic        sof;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int out_idx = 0;

  logic        mon_en  = 1'b1;
  logic        lat_chk = 1'b1;
  logic        stall_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [23:0] held_pix;
  logic        held_sof;
  logic [0:15] stall_pat = 16'b1001_0110_1001_1111;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Sink ready: held high except during the stall test, where it follows a pattern.
  initial begin
    int sidx;
    sidx = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (stall_en) begin
        out_ready = stall_pat[sidx];
        sidx = (sidx + 1) % 16;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_pix", {8'd0, out_pix}, {8'd0, held_pix});
        check("stall_sof", {31'd0, out_sof}, {31'd0, held_sof});
      end
      if (stall_en && out_valid)
        check("in_ready_stall", {31'd0, in_ready}, {31'd0, out_ready});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("pix#%0d", out_idx), {8'd0, out_pix}, {8'd0, mon_e.pix});
          check($sformatf("sof#%0d", out_idx), {31'd0, out_sof}, {31'd0, mon_e.sof});
          if (lat_chk)
            check($sformatf("latency#%0d", out_idx), cyc - mon_e.acc_cyc, 32'd2);
          out_idx++;
        end
      end
      prev_stall = out_valid && !out_ready;
      held_pix   = out_pix;
      held_sof   = out_sof;
    end
  end

  // Present one pixel (called just after a rising edge) and wait, bounded,
  // until it is accepted; returns just after the accepting edge.
  task automatic send(input logic [23:0] pix, input logic sof, input logic [1:0] md,
                      input logic [8:0] thr, input logic [23:0] want);
    exp_t e;
    logic acc;
    acc = 1'b0;
    in_pix = pix;
    in_sof = sof;
    mode = md;
    threshold = thr;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (acc) begin
      e.pix = want;
      e.sof = sof;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
    end else begin
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clock);
    #1;
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_pix = '0;
    in_sof = 1'b0;
    threshold = '0;
    mode = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pix", {8'd0, out_pix}, 32'd0);
    check("rst_out_sof", {31'd0, out_sof}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;

    // Horizontal gradient on a short gray ramp.
    send(24'h101010, 1'b1, 2'd0, 9'd16, BG);
    send(24'h202020, 1'b0, 2'd0, 9'd16, EDGE);
    send(24'h101010, 1'b0, 2'd0, 9'd16, EDGE);
    send(24'h101010, 1'b0, 2'd0, 9'd16, BG);
    idle();
    drain("drain_ramp");

    // Vertical gradient: row 0 is forced flat, row 1 sees V=112.
    for (int i = 0; i < 4; i++) send(24'h101010, i == 0, 2'd1, 9'd100, BG);
    for (int i = 0; i < 4; i++) send(24'h808080, 1'b0, 2'd1, 9'd100, EDGE);
    idle();
    drain("drain_vert");

    // H+V below threshold everywhere.
    for (int i = 0; i < 4; i++) send(24'h101010, i == 0, 2'd2, 9'd200, BG);
    for (int i = 0; i < 4; i++) send(24'h808080, 1'b0, 2'd2, 9'd200, BG);
    // H+V with a bright pixel in row 1: 239+239=478.
    for (int i = 0; i < 4; i++) send(24'h101010, i == 0, 2'd2, 9'd200, BG);
    send(24'h101010, 1'b0, 2'd2, 9'd200, BG);
    send(24'hFFFFFF, 1'b0, 2'd2, 9'd200, EDGE);
    send(24'h101010, 1'b0, 2'd2, 9'd200, EDGE);
    send(24'h101010, 1'b0, 2'd2, 9'd200, BG);
    idle();
    drain("drain_sum");

    // Sink back-pressure.
    stall_en = 1'b1;
    lat_chk = 1'b0;
    send(24'h000000, 1'b1, 2'd0, 9'd16, BG);
    send(24'h303030, 1'b0, 2'd0, 9'd16, EDGE);
    send(24'h303030, 1'b0, 2'd0, 9'd16, BG);
    send(24'h050505, 1'b0, 2'd0, 9'd16, EDGE);
    send(24'h202020, 1'b0, 2'd0, 9'd16, BG);
    send(24'h000000, 1'b0, 2'd0, 9'd16, EDGE);
    send(24'h101010, 1'b0, 2'd0, 9'd16, EDGE);
    send(24'h101010, 1'b0, 2'd0, 9'd16, BG);
    idle();
    drain("drain_stall");
    stall_en = 1'b0;
    @(posedge clock);
    #1;
    lat_chk = 1'b1;

    // Reset mid-frame after 6 of 8 pixels; in-flight pixels are discarded.
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) send(24'h808080, i == 0, 2'd0, 9'd1, BG);
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_sof", {31'd0, out_sof}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    // No in_sof: the first pixel must be col 0 (left was 128, so a stale col gives white).
    send(24'h000000, 1'b0, 2'd0, 9'd1, BG);
    send(24'h808080, 1'b0, 2'd0, 9'd1, EDGE);
    send(24'h808080, 1'b0, 2'd0, 9'd1, BG);
    send(24'h000000, 1'b0, 2'd0, 9'd1, EDGE);
    idle();
    drain("drain_midrst");

    // max(H,V) right at the threshold, then one above it.
    send(24'h000000, 1'b1, 2'd3, 9'd63, BG);
    send(24'hFF0000, 1'b0, 2'd3, 9'd63, EDGE);
    send(24'h000000, 1'b1, 2'd3, 9'd64, BG);
    send(24'hFF0000, 1'b0, 2'd3, 9'd64, BG);
    // Threshold 0 marks even a flat col-0 pixel; 511 exceeds any G.
    send(24'h000000, 1'b1, 2'd0, 9'd0, EDGE);
    send(24'hFFFFFF, 1'b0, 2'd2, 9'd511, BG);
    send(24'h000000, 1'b0, 2'd2, 9'd255, EDGE);
    idle();
    drain("drain_thr");

    repeat (4) @(posedge clock);
    check("final_queue", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
